// File: rtl/data_mem.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// then performs a little-endian byte/half/word access and pulses ack (with err on a bad request).
module data_mem #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [5:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_busy
);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {StIdle, StWait, StResp, StErr} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ack, r_err, r_busy;
    logic [31:0]      r_rdata;
    logic [5:0]       r_op;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_mem [DEPTH];

    logic        w_accept, w_bad, w_op_ok, w_half_op, w_word_op;
    logic [31:0] w_word, w_load, w_st_data;
    logic [3:0]  w_st_be;
    logic        w_store;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_accept = (r_state == StIdle) && i_req;

    always_comb begin
        w_op_ok   = 1'b1;
        w_half_op = 1'b0;
        w_word_op = 1'b0;
        case (i_op)
            OP_LB, OP_LBU, OP_SB: w_op_ok   = 1'b1;
            OP_LH, OP_LHU, OP_SH: w_half_op = 1'b1;
            OP_LW, OP_SW:         w_word_op = 1'b1;
            default:              w_op_ok   = 1'b0;
        endcase
    end

    assign w_bad = !w_op_ok || (w_half_op && i_addr[0]) ||
                   (w_word_op && (i_addr[1:0] != 2'b00)) ||
                   (i_addr[31:ADDR_W+2] != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle: begin
                if (i_req) begin
                    w_cnt_nxt = '0;
                    if (w_bad)                 w_state_nxt = StErr;
                    else if (WAIT_CYCLES == 0) w_state_nxt = StResp;
                    else                       w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (r_cnt == CNT_LAST) w_state_nxt = StResp;
                else                   w_cnt_nxt = r_cnt + 1'b1;
            end
            StResp, StErr: w_state_nxt = StIdle;
            default:       w_state_nxt = StIdle;
        endcase
    end

    // Ack cycle is spent in IDLE, so a held request is taken on the edge that drops ack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= (r_state == StResp) || (r_state == StErr);
            r_err   <= (r_state == StErr);
            r_busy  <= (r_state == StIdle) ? i_req : 1'b1;
            if (r_state == StErr)       r_rdata <= '0;
            else if (r_state == StResp) r_rdata <= w_load;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_op    <= i_op;
            r_addr  <= i_addr[ADDR_W+1:0];
            r_wdata <= i_wdata;
        end
    end

    assign w_word = r_mem[r_addr[ADDR_W+1:2]];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        w_load    = '0;
        w_store   = 1'b0;
        w_st_be   = '0;
        w_st_data = r_wdata;
        case (r_op)
            OP_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU: w_load = {24'h0, w_byte};
            OP_LH:  w_load = {{16{w_half[15]}}, w_half};
            OP_LHU: w_load = {16'h0, w_half};
            OP_LW:  w_load = w_word;
            OP_SB: begin
                w_store   = 1'b1;
                w_st_be   = 4'b0001 << r_addr[1:0];
                w_st_data = {4{r_wdata[7:0]}};
            end
            OP_SH: begin
                w_store   = 1'b1;
                w_st_be   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{r_wdata[15:0]}};
            end
            OP_SW: begin
                w_store = 1'b1;
                w_st_be = 4'b1111;
            end
            default: w_load = '0;
        endcase
    end

    // RESP is only ever reached for a validated request, and reset forces IDLE.
    always_ff @(posedge i_clk) begin
        if ((r_state == StResp) && w_store) begin
            for (int k = 0; k < 4; k++) begin
                if (w_st_be[k]) r_mem[r_addr[ADDR_W+1:2]][8*k +: 8] <= w_st_data[8*k +: 8];
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_ack   = r_ack;
    assign o_err   = r_err;
    assign o_busy  = r_busy;
endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance share stimulus and are
// checked against a byte-addressed reference memory.
module tb_data_mem;
    localparam int W = 2;
    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    logic        clk = 1'b0;
    logic        rst_n, rst0_n, req;
    logic [5:0]  op;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, rdata0;
    logic        ack, err, busy, ack0, err0, busy0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mb [0:4095];

    data_mem #(.ADDR_W(10), .WAIT_CYCLES(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_op(op), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata), .o_ack(ack), .o_err(err), .o_busy(busy)
    );

    data_mem #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst0_n), .i_req(req), .i_op(op), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata0), .o_ack(ack0), .o_err(err0), .o_busy(busy0)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_eval(input logic [5:0] o, input logic [31:0] a,
                                       output logic e, output logic [31:0] rd,
                                       output int n, output bit st);
        bit sgn, ld;
        sgn = 0; ld = 0; st = 0; n = 0;
        case (o)
            LB:  begin n = 1; sgn = 1; ld = 1; end
            LH:  begin n = 2; sgn = 1; ld = 1; end
            LW:  begin n = 4; ld = 1; end
            LBU: begin n = 1; ld = 1; end
            LHU: begin n = 2; ld = 1; end
            SB:  begin n = 1; st = 1; end
            SH:  begin n = 2; st = 1; end
            SW:  begin n = 4; st = 1; end
            default: n = 0;
        endcase
        e = (n == 0) || (a >= 32'h1000) || ((a % n) != 0);
        rd = '0;
        if (!e && ld) begin
            for (int i = 0; i < n; i++) rd = rd | (32'(mb[a+i]) << (8*i));
            if (sgn && rd[8*n-1]) for (int i = 8*n; i < 32; i++) rd[i] = 1'b1;
        end
    endfunction

    task automatic txn(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd);
        logic e;
        logic [31:0] rd;
        int n, lat, cyc;
        bit st, seen;
        model_eval(o, a, e, rd, n, st);
        lat = e ? 1 : W + 1;
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; op = 6'($urandom); addr = $urandom; wdata = $urandom;
        check("busy_at_accept", busy, 1);
        cyc = 0; seen = 0;
        while (!seen && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            check("busy_hold", busy, 1);
            if (cyc == 1) begin
                check("w0_ack", ack0, 1);
                check("w0_err", err0, e);
                check("w0_rdata", rdata0, rd);
            end
            if (ack === 1'b1) seen = 1;
        end
        check("ack_latency", cyc, lat);
        check("err", err, e);
        check("rdata", rdata, rd);
        @(posedge clk); #1;
        check("ack_drop", ack, 0);
        check("busy_drop", busy, 0);
        check("rdata_hold", rdata, rd);
        check("w0_busy_drop", busy0, 0);
        if (!e && st) for (int i = 0; i < n; i++) mb[a+i] = wd[8*i +: 8];
    endtask

    initial begin
        logic [5:0] ops_tbl [8];
        logic [5:0] ro;
        logic [31:0] ra;
        logic e;
        logic [31:0] rd, exp2, exp0;
        int n, next2, next0, pend2, pend0;
        bit st;
        ops_tbl = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

        rst_n = 1'b0; rst0_n = 1'b0; req = 1'b0; op = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 0);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1; rst0_n = 1'b1;

        for (int i = 0; i < 64; i++) txn(SW, 32'(i * 4), $urandom);

        txn(SW, 32'h10, 32'h12345678);
        txn(LW, 32'h10, 32'h0);
        txn(SB, 32'h11, 32'h80);
        txn(LB, 32'h11, 32'h0);
        txn(LBU, 32'h11, 32'h0);
        txn(LW, 32'h10, 32'h0);
        txn(LH, 32'h4925, 32'h0);
        txn(SH, 32'h12, 32'h0000BEEF);
        txn(LHU, 32'h12, 32'h0);
        txn(LH, 32'h12, 32'h0);
        txn(LW, 32'h1000, 32'h0);
        txn(6'b000000, 32'h10, 32'h0);
        txn(SW, 32'h16, 32'hCAFEF00D);
        txn(LW, 32'h14, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int idx;
            idx = $urandom_range(0, 8);
            ro = (idx == 8) ? 6'($urandom) : ops_tbl[idx];
            ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            txn(ro, ra, $urandom);
        end

        // Store abandoned by reset during its wait states
        txn(SW, 32'h20, 32'h0);
        txn(LW, 32'h10, 32'h0);
        @(negedge clk);
        rst0_n = 1'b0;
        req = 1'b1; op = SW; addr = 32'h20; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ack", ack, 0);
        check("abort_err", err, 0);
        check("abort_busy_rst", busy, 0);
        check("abort_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1; rst0_n = 1'b1;
        txn(LW, 32'h20, 32'h0);

        // Request held high with changing inputs: one accept per W+2 cycles
        next2 = 1; next0 = 1; pend2 = -1; pend0 = -1; exp2 = '0; exp0 = '0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                ro = LW; ra = 32'($urandom_range(0, 63)) << 2;
            end else begin
                ro = LBU; ra = 32'($urandom_range(0, 255));
            end
            req = 1'b1; op = ro; addr = ra; wdata = $urandom;
            model_eval(ro, ra, e, rd, n, st);
            @(posedge clk);
            if (k >= next2) begin pend2 = k + W + 1; next2 = k + W + 2; exp2 = rd; end
            if (k >= next0) begin pend0 = k + 1;     next0 = k + 2;     exp0 = rd; end
            #1;
            check("hold_ack", ack, (k == pend2));
            check("hold_busy", busy, 1);
            check("hold_w0_ack", ack0, (k == pend0));
            check("hold_w0_busy", busy0, 1);
            if (k == pend2) check("hold_rdata", rdata, exp2);
            if (k == pend0) check("hold_w0_rdata", rdata0, exp0);
        end
        @(negedge clk);
        req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("hold_end_busy", busy, 0);
        check("hold_end_w0_busy", busy0, 0);
        check("hold_end_rdata", rdata, exp2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
